pipe_stage_sequencer: RTL and testbench
=======================================

Name: pipe_stage_sequencer

Overview:
Parametrised multicycle pipeline sequencer for the CPU core. It strobes one pipeline-register enable per cycle across NUM_STAGES stages, then holds for WB_CYCLES write-back cycles, then issues a PC load. Beyond the fixed 4-stage sequencer, it adds stall (freeze), flush (restart), a sticky halt when the instruction index runs past the program, and a retired-instruction counter. It sits beside the datapath and drives the inter-stage register enables and the PC load.

Parameters:
WIDTH, 32, width of curr_inst.
INSTRACTION_NUMBERS, 16, program length; PC load is allowed only while curr_inst < this value.
NUM_STAGES, 4, number of pipeline-register enables; legal range 2..16.
WB_CYCLES, 1, write-back dwell cycles after the last stage; legal range 0..15.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
curr_inst  input  WIDTH  current instruction index (unsigned).
stall  input  1  freeze the sequencer in its current state.
flush  input  1  abort the current instruction; restart at stage 0.
stage_open  output  NUM_STAGES  one-hot stage-register enable (bit 0 = IF/ID).
is_load_PC  output  1  one-cycle PC load strobe.
halted  output  1  high while in S_HALT.
curr_state  output  2  S_STAGE=0, S_WRITE=1, S_LOAD_PC=2, S_HALT=3.
stage_idx  output  4  active stage index while in S_STAGE.
inst_count  output  CNT_W  count of PC loads issued, saturating.

Behaviour:
- Registers: state, stage_idx, wb_cnt (4 bits), inst_count. Every output is a combinational decode of these registers plus stall and curr_inst (Moore-style, no extra latency).
- Reset (rst high at a clk edge): state=S_STAGE, stage_idx=0, wb_cnt=0, inst_count=0. While rst is held, stage_open=1 (unless stall), is_load_PC=0, halted=0.
- Edge priority: rst > flush > stall > normal transition.
- flush: state=S_STAGE, stage_idx=0, wb_cnt=0, from any state including S_HALT. inst_count is unchanged.
- stall: all registers hold. Outputs in the stalled cycle: stage_open=0 and is_load_PC=0. stall has no effect in S_HALT.
- S_STAGE:
  - stage_open = 1 << stage_idx when not stalled.
  - If stage_idx < NUM_STAGES-1: stage_idx increments.
  - Otherwise: go to S_WRITE with wb_cnt=0 if WB_CYCLES > 0, or go directly to S_LOAD_PC if WB_CYCLES = 0.
- S_WRITE:
  - All enables are 0.
  - wb_cnt increments each cycle; when wb_cnt == WB_CYCLES-1, go to S_LOAD_PC.
- S_LOAD_PC:
  - If curr_inst < INSTRACTION_NUMBERS: is_load_PC=1 for this cycle; next state=S_STAGE, stage_idx=0; inst_count increments, saturating at all-ones.
  - Otherwise: is_load_PC=0 and next state=S_HALT.
- S_HALT: all enables are 0; halted=1. Leaves only on rst or flush.
- Unstalled period per instruction = NUM_STAGES + WB_CYCLES + 1 cycles (6 with default parameters).
- Comparison curr_inst < INSTRACTION_NUMBERS is unsigned and uses the full WIDTH.
- At most one bit of stage_open is ever high, and stage_open and is_load_PC are never high together.

Test Plan:
1. Defaults, stall=0, curr_inst=3 → stage_open follows 0001, 0010, 0100, 1000, 0000 (S_WRITE), then 0000 with is_load_PC=1; the pattern repeats every 6 cycles; inst_count=2 after 12 cycles.
2. curr_inst=16 when S_LOAD_PC is reached → is_load_PC=0; next cycle curr_state=3, halted=1; stage_open stays 0 for 10 further cycles; flush then gives stage_open=0001 on the following cycle.
3. stall held 3 cycles while stage_idx=2 → stage_open=0 and stage_idx=2 for those 3 cycles; stage_open=0100 on release, then 1000; period becomes 9 cycles.
4. flush asserted in S_WRITE with stall also high → next cycle stage_open=0001; inst_count unchanged; no is_load_PC pulse.
5. rst asserted for 1 cycle at stage_idx=3 with inst_count=5 → next cycle curr_state=0, stage_idx=0, inst_count=0.
6. NUM_STAGES=5, WB_CYCLES=0 → stage_open walks 00001 to 10000, then S_LOAD_PC directly; period 6 cycles; S_WRITE (curr_state=1) is never visited.

Source files
------------

// File: rtl/pipe_stage_sequencer_if.sv
// Bundle of datapath-facing signals for pipe_stage_sequencer.
// The master drives instruction index, stall and flush; the slave (sequencer) drives enables and status.
interface pipe_stage_sequencer_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 16
);
    logic [WIDTH-1:0]      curr_inst;
    logic                  stall;
    logic                  flush;
    logic [NUM_STAGES-1:0] stage_open;
    logic                  is_load_PC;
    logic                  halted;
    logic [1:0]            curr_state;
    logic [3:0]            stage_idx;
    logic [CNT_W-1:0]      inst_count;

    modport master (
        output curr_inst, stall, flush,
        input  stage_open, is_load_PC, halted, curr_state, stage_idx, inst_count
    );

    modport slave (
        input  curr_inst, stall, flush,
        output stage_open, is_load_PC, halted, curr_state, stage_idx, inst_count
    );
endinterface

// File: rtl/pipe_stage_sequencer.sv
// Multicycle pipeline sequencer: walks one-hot stage enables, dwells for write-back,
// then pulses a PC load; supports stall, flush, sticky halt past the program end and a retire counter.
module pipe_stage_sequencer #(
    parameter int WIDTH               = 32,
    parameter int INSTRACTION_NUMBERS = 16,
    parameter int NUM_STAGES          = 4,
    parameter int WB_CYCLES           = 1,
    parameter int CNT_W               = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipe_stage_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {
        S_STAGE   = 2'd0,
        S_WRITE   = 2'd1,
        S_LOAD_PC = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [3:0]       LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [3:0]       LAST_WB    = (WB_CYCLES > 0) ? 4'(WB_CYCLES - 1) : 4'd0;
    localparam logic [WIDTH-1:0] INST_LIMIT = WIDTH'(INSTRACTION_NUMBERS);

    state_t                state, state_n;
    logic [3:0]            stage_idx, stage_idx_n;
    logic [3:0]            wb_cnt, wb_cnt_n;
    logic [CNT_W-1:0]      inst_count, inst_count_n;
    logic [NUM_STAGES-1:0] stage_open;
    logic                  load_pc;
    logic                  inst_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_STAGE;
            stage_idx  <= 4'd0;
            wb_cnt     <= 4'd0;
            inst_count <= '0;
        end else begin
            state      <= state_n;
            stage_idx  <= stage_idx_n;
            wb_cnt     <= wb_cnt_n;
            inst_count <= inst_count_n;
        end
    end

    // Outputs depend only on registered state plus stall and curr_inst, so they appear in the same cycle.
    always_comb begin
        state_n      = state;
        stage_idx_n  = stage_idx;
        wb_cnt_n     = wb_cnt;
        inst_count_n = inst_count;
        stage_open   = '0;
        load_pc      = 1'b0;
        inst_ok      = (bus.curr_inst < INST_LIMIT);

        if (!bus.stall) begin
            if (state == S_STAGE) begin
                stage_open = NUM_STAGES'(1) << stage_idx;
            end
            if (state == S_LOAD_PC && inst_ok) begin
                load_pc = 1'b1;
            end
        end

        if (bus.flush) begin
            state_n     = S_STAGE;
            stage_idx_n = 4'd0;
            wb_cnt_n    = 4'd0;
        end else if (!bus.stall) begin
            case (state)
                S_STAGE: begin
                    if (stage_idx < LAST_STAGE) begin
                        stage_idx_n = stage_idx + 4'd1;
                    end else if (WB_CYCLES > 0) begin
                        state_n  = S_WRITE;
                        wb_cnt_n = 4'd0;
                    end else begin
                        state_n = S_LOAD_PC;
                    end
                end
                S_WRITE: begin
                    wb_cnt_n = wb_cnt + 4'd1;
                    if (wb_cnt == LAST_WB) begin
                        state_n = S_LOAD_PC;
                    end
                end
                S_LOAD_PC: begin
                    if (inst_ok) begin
                        state_n     = S_STAGE;
                        stage_idx_n = 4'd0;
                        if (inst_count != {CNT_W{1'b1}}) begin
                            inst_count_n = inst_count + 1'b1;
                        end
                    end else begin
                        state_n = S_HALT;
                    end
                end
                default: begin
                    state_n = S_HALT;
                end
            endcase
        end
    end

    assign bus.stage_open = stage_open;
    assign bus.is_load_PC = load_pc;
    assign bus.halted     = (state == S_HALT);
    assign bus.curr_state = state;
    assign bus.stage_idx  = stage_idx;
    assign bus.inst_count = inst_count;

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// Scoreboard bench for pipe_stage_sequencer: default build (4 stages, 1 WB cycle) and a
// 5-stage / 0-WB build, each driven in turn while the other is held in reset.
module tb_pipe_stage_sequencer;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_stage_sequencer_if #(.WIDTH(32), .NUM_STAGES(4), .CNT_W(16)) if_a ();
    pipe_stage_sequencer_if #(.WIDTH(32), .NUM_STAGES(5), .CNT_W(16)) if_b ();

    pipe_stage_sequencer #(
        .WIDTH(32), .INSTRACTION_NUMBERS(16), .NUM_STAGES(4), .WB_CYCLES(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave)
    );

    pipe_stage_sequencer #(
        .WIDTH(32), .INSTRACTION_NUMBERS(16), .NUM_STAGES(5), .WB_CYCLES(0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave)
    );

    typedef struct {
        int          sel;
        logic [15:0] so;
        logic        ld;
        logic        hl;
        logic [1:0]  st;
        logic [3:0]  idx;
        logic        chk_idx;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          m_pos[2];
    bit          m_halt[2];
    bit          m_valid[2];
    logic [15:0] m_cnt[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model tracks position within the instruction period rather than an explicit state.
    task automatic applyStimulus(input int sel, input logic r, input logic s, input logic f,
                                 input logic [31:0] inst);
        exp_t e;
        int   ns, wb, o;
        @(negedge clk);
        if (sel == 0) begin
            rst_a = r; if_a.stall = s; if_a.flush = f; if_a.curr_inst = inst;
            rst_b = 1'b1; if_b.stall = 1'b0; if_b.flush = 1'b0; if_b.curr_inst = 32'd0;
        end else begin
            rst_b = r; if_b.stall = s; if_b.flush = f; if_b.curr_inst = inst;
            rst_a = 1'b1; if_a.stall = 1'b0; if_a.flush = 1'b0; if_a.curr_inst = 32'd0;
        end
        #1;
        ns = (sel == 0) ? 4 : 5;
        wb = (sel == 0) ? 1 : 0;
        o  = 1 - sel;
        if (m_valid[sel]) begin
            e.sel = sel; e.so = '0; e.ld = 1'b0; e.hl = 1'b0; e.idx = '0; e.chk_idx = 1'b0;
            e.cnt = m_cnt[sel];
            if (m_halt[sel]) begin
                e.st = 2'd3; e.hl = 1'b1;
            end else if (m_pos[sel] < ns) begin
                e.st = 2'd0; e.idx = 4'(m_pos[sel]); e.chk_idx = 1'b1;
                if (!s) e.so = 16'h1 << m_pos[sel];
            end else if (m_pos[sel] < ns + wb) begin
                e.st = 2'd1;
            end else begin
                e.st = 2'd2; e.ld = !s && (inst < 32'd16);
            end
            sb.push_back(e);
        end
        if (r) begin
            m_pos[sel] = 0; m_halt[sel] = 1'b0; m_cnt[sel] = '0; m_valid[sel] = 1'b1;
        end else if (f) begin
            m_pos[sel] = 0; m_halt[sel] = 1'b0;
        end else if (!s && !m_halt[sel]) begin
            if (m_pos[sel] == ns + wb) begin
                if (inst < 32'd16) begin
                    m_pos[sel] = 0;
                    if (m_cnt[sel] != 16'hFFFF) m_cnt[sel] = m_cnt[sel] + 16'd1;
                end else begin
                    m_halt[sel] = 1'b1;
                end
            end else begin
                m_pos[sel] = m_pos[sel] + 1;
            end
        end
        m_pos[o] = 0; m_halt[o] = 1'b0; m_cnt[o] = '0; m_valid[o] = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] so, cnt;
        logic        ld, hl;
        logic [1:0]  st;
        logic [3:0]  idx;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                so = 16'(if_a.stage_open); ld = if_a.is_load_PC; hl = if_a.halted;
                st = if_a.curr_state; idx = if_a.stage_idx; cnt = if_a.inst_count;
            end else begin
                so = 16'(if_b.stage_open); ld = if_b.is_load_PC; hl = if_b.halted;
                st = if_b.curr_state; idx = if_b.stage_idx; cnt = if_b.inst_count;
            end
            check("stage_open", 32'(so), 32'(e.so));
            check("is_load_PC", 32'(ld), 32'(e.ld));
            check("halted", 32'(hl), 32'(e.hl));
            check("curr_state", 32'(st), 32'(e.st));
            check("inst_count", 32'(cnt), 32'(e.cnt));
            if (e.chk_idx) check("stage_idx", 32'(idx), 32'(e.idx));
        end
    endtask

    initial begin
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        m_pos[0] = 0; m_pos[1] = 0; m_halt[0] = 1'b0; m_halt[1] = 1'b0;
        m_cnt[0] = '0; m_cnt[1] = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.stall = 1'b0; if_a.flush = 1'b0; if_a.curr_inst = 32'd0;
        if_b.stall = 1'b0; if_b.flush = 1'b0; if_b.curr_inst = 32'd0;
        $display("[TB] start");

        // Reset and free-running default build.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd3); checkOutput();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd3); checkOutput();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t1_inst_count", 32'(if_a.inst_count), 32'd2);

        // Program end reached: halt is sticky until flush.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd16); checkOutput();
        check("t2_no_load", 32'(if_a.is_load_PC), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd16); checkOutput();
        check("t2_halted", 32'(if_a.halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0, (i % 3) == 0, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'd3); checkOutput();

        // Stall held for three cycles at stage 2.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t2_after_flush", 32'(if_a.stage_open), 32'h1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t3_release", 32'(if_a.stage_open), 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        end

        // Flush with stall during write-back.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 32'd3); checkOutput();
        check("t4_in_write", 32'(if_a.curr_state), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t4_restart", 32'(if_a.stage_open), 32'h1);
        check("t4_count_kept", 32'(if_a.inst_count), 32'd3);

        // Reset mid-instruction with a non-zero retire count.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        end
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t5_pre_count", 32'(if_a.inst_count), 32'd5);
        check("t5_pre_idx", 32'(if_a.stage_idx), 32'd3);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
        check("t5_post_count", 32'(if_a.inst_count), 32'd0);
        check("t5_post_idx", 32'(if_a.stage_idx), 32'd0);

        // Five stages, no write-back dwell.
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd3); checkOutput();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd3); checkOutput();
            check("t6_no_write", 32'(if_b.curr_state != 2'd1), 32'd1);
        end
        check("t6_inst_count", 32'(if_b.inst_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
